// File: rtl/y86_pkg.sv
// y86_pkg -- definitions shared by the Y86-64 pipeline blocks.
//
// Holds the machine word / instruction widths, the instruction and status
// codes used across the pipeline, and the state encoding of the memory
// port arbiter that lets fetch and memory stages share one memory port.
package y86_pkg;

   localparam int WORD_W      = 64;
   localparam int INSTR_W     = 80;
   localparam int INSTR_BYTES = INSTR_W / 8;

   typedef logic [WORD_W-1:0]  word_t;
   typedef logic [INSTR_W-1:0] instr_t;

   // Instruction codes (icode field)
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   // Processor status codes
   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   // Memory port arbiter states
   typedef enum logic [2:0] {
      ARB_IDLE = 3'd0,
      ARB_DM   = 3'd1,
      ARB_IF0  = 3'd2,
      ARB_IF1  = 3'd3,
      ARB_RESP = 3'd4
   } arb_state_t;

   // Address of the second 8-byte word of a fetch; wraps modulo 2^64.
   function automatic word_t next_fetch_word(input word_t addr);
      return addr + word_t'(8);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if -- bundle of the arbiter's handshake signals.
//
// Groups three channels:
//   fetch  : if_req/if_addr in, if_valid/if_bytes/if_err out
//   data   : dm_req/dm_we/dm_addr/dm_wdata in, dm_valid/dm_rdata/dm_err out
//   memory : mem_req/mem_we/mem_addr/mem_wdata out, mem_ack/mem_rdata/mem_err in
// Modport slave is the arbiter's view; modport master is the view of the
// environment (pipeline stages plus unified memory).
interface mem_port_arbiter_if;
   import y86_pkg::*;

   logic   if_req;
   word_t  if_addr;
   logic   if_valid;
   instr_t if_bytes;
   logic   if_err;

   logic   dm_req;
   logic   dm_we;
   word_t  dm_addr;
   word_t  dm_wdata;
   logic   dm_valid;
   word_t  dm_rdata;
   logic   dm_err;

   logic   mem_req;
   logic   mem_we;
   word_t  mem_addr;
   word_t  mem_wdata;
   logic   mem_ack;
   word_t  mem_rdata;
   logic   mem_err;

   modport slave (
      input  if_req, if_addr,
      output if_valid, if_bytes, if_err,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_valid, dm_rdata, dm_err,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata, mem_err
   );

   modport master (
      output if_req, if_addr,
      input  if_valid, if_bytes, if_err,
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_valid, dm_rdata, dm_err,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata, mem_err
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter -- shares one unified memory port between the fetch stage
// and the memory stage.
//
// Ports:
//   clk    : single clock, all state on rising edge
//   reset  : synchronous active-high reset
//   bus    : mem_port_arbiter_if.slave (fetch, data and memory channels)
//
// A data access takes one memory transaction (DM). A fetch needs 10 bytes
// and the port returns 8, so it takes two transactions (IF0 at addr, IF1 at
// addr+8). Every access ends in a one-cycle RESP state that pulses the
// matching valid. When both requesters wait in IDLE, the one not served last
// wins, so neither waits for more than one foreign access.
module mem_port_arbiter
   import y86_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);

   arb_state_t state_reg, state_next;
   logic       last_dm_reg, last_dm_next;   // 1: last completed access was data
   logic       resp_dm_reg, resp_dm_next;   // which valid RESP pulses
   word_t      acc_addr_reg, acc_addr_next; // request captured at grant
   logic       acc_we_reg, acc_we_next;
   word_t      acc_wdata_reg, acc_wdata_next;
   word_t      fetch_lo_reg, fetch_lo_next; // bytes 0-7 while IF1 is pending
   instr_t     if_bytes_reg, if_bytes_next;
   logic       if_err_reg, if_err_next;
   word_t      dm_rdata_reg, dm_rdata_next;
   logic       dm_err_reg, dm_err_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ARB_IDLE;
         last_dm_reg   <= 1'b0;
         resp_dm_reg   <= 1'b0;
         acc_addr_reg  <= '0;
         acc_we_reg    <= 1'b0;
         acc_wdata_reg <= '0;
         fetch_lo_reg  <= '0;
         if_bytes_reg  <= '0;
         if_err_reg    <= 1'b0;
         dm_rdata_reg  <= '0;
         dm_err_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         last_dm_reg   <= last_dm_next;
         resp_dm_reg   <= resp_dm_next;
         acc_addr_reg  <= acc_addr_next;
         acc_we_reg    <= acc_we_next;
         acc_wdata_reg <= acc_wdata_next;
         fetch_lo_reg  <= fetch_lo_next;
         if_bytes_reg  <= if_bytes_next;
         if_err_reg    <= if_err_next;
         dm_rdata_reg  <= dm_rdata_next;
         dm_err_reg    <= dm_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      last_dm_next   = last_dm_reg;
      resp_dm_next   = resp_dm_reg;
      acc_addr_next  = acc_addr_reg;
      acc_we_next    = acc_we_reg;
      acc_wdata_next = acc_wdata_reg;
      fetch_lo_next  = fetch_lo_reg;
      if_bytes_next  = if_bytes_reg;
      if_err_next    = if_err_reg;
      dm_rdata_next  = dm_rdata_reg;
      dm_err_next    = dm_err_reg;

      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = acc_addr_reg;
      bus.mem_wdata  = acc_wdata_reg;
      bus.if_valid   = 1'b0;
      bus.dm_valid   = 1'b0;

      unique case (state_reg)
         ARB_IDLE: begin
            // Data wins unless both request and data was served last.
            if (bus.dm_req && (!bus.if_req || !last_dm_reg)) begin
               state_next     = ARB_DM;
               acc_addr_next  = bus.dm_addr;
               acc_we_next    = bus.dm_we;
               acc_wdata_next = bus.dm_wdata;
            end else if (bus.if_req) begin
               state_next     = ARB_IF0;
               acc_addr_next  = bus.if_addr;
               acc_we_next    = 1'b0;
               acc_wdata_next = '0;
            end
         end

         ARB_DM: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = acc_we_reg;
            if (bus.mem_ack) begin
               dm_rdata_next = acc_we_reg ? '0 : bus.mem_rdata;
               dm_err_next   = bus.mem_err;
               last_dm_next  = 1'b1;
               resp_dm_next  = 1'b1;
               state_next    = ARB_RESP;
            end
         end

         ARB_IF0: begin
            bus.mem_req = 1'b1;
            if (bus.mem_ack) begin
               fetch_lo_next = bus.mem_rdata;
               if (bus.mem_err) begin
                  // Faulting first word: no point reading the second one.
                  if_bytes_next = {16'h0, bus.mem_rdata};
                  if_err_next   = 1'b1;
                  last_dm_next  = 1'b0;
                  resp_dm_next  = 1'b0;
                  state_next    = ARB_RESP;
               end else begin
                  state_next    = ARB_IF1;
               end
            end
         end

         ARB_IF1: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = next_fetch_word(acc_addr_reg);
            if (bus.mem_ack) begin
               if_bytes_next = {bus.mem_rdata[15:0], fetch_lo_reg};
               if_err_next   = bus.mem_err;
               last_dm_next  = 1'b0;
               resp_dm_next  = 1'b0;
               state_next    = ARB_RESP;
            end
         end

         ARB_RESP: begin
            bus.dm_valid = resp_dm_reg;
            bus.if_valid = !resp_dm_reg;
            state_next   = ARB_IDLE;
         end

         default: state_next = ARB_IDLE;
      endcase
   end

   assign bus.if_bytes = if_bytes_reg;
   assign bus.if_err   = if_err_reg;
   assign bus.dm_rdata = dm_rdata_reg;
   assign bus.dm_err   = dm_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter -- scoreboard bench for mem_port_arbiter.
//
// A behavioural memory answers the shared port after a programmable number
// of wait cycles, with data derived from the address. Each started request
// pushes its expected result into a queue; the result is popped and compared
// when the matching valid pulse appears.
module tb_mem_port_arbiter;
   import y86_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus();

   mem_port_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct { logic [79:0] bytes; logic err; logic chk; } if_exp_t;
   typedef struct { logic [63:0] rdata; logic err; } dm_exp_t;
   typedef struct { logic [63:0] addr; logic we; } grant_t;

   int vectors    = 0;
   int miscompares = 0;

   if_exp_t if_q[$];
   dm_exp_t dm_q[$];
   grant_t  grant_q[$];

   // memory model controls
   int          mem_wait  = 0;
   logic        err_en    = 1'b0;
   logic [63:0] err_addr  = 64'h0;
   logic [63:0] ovr [logic [63:0]];
   int          stray_ack = 0;
   logic        addr_moved = 1'b0;
   logic [63:0] hold_addr = 64'h0;
   int          ack_count = 0;

   function automatic logic [63:0] mem_word(input logic [63:0] a);
      if (ovr.exists(a)) return ovr[a];
      return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
   endfunction

   function automatic logic mem_fault(input logic [63:0] a);
      return err_en && (a == err_addr);
   endfunction

   // Memory responder: acks after mem_wait cycles, tracks address stability.
   initial begin
      int cnt;
      cnt = 0;
      bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;
      forever begin
         @(negedge clk);
         if (stray_ack > 0) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            bus.mem_err = 1'b1; stray_ack--; cnt = 0;
         end else if (bus.mem_req === 1'b1 && !reset) begin
            if (cnt == 0) hold_addr = bus.mem_addr;
            else if (bus.mem_addr !== hold_addr) addr_moved = 1'b1;
            if (cnt >= mem_wait) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem_word(bus.mem_addr);
               bus.mem_err   = mem_fault(bus.mem_addr);
               grant_q.push_back('{bus.mem_addr, bus.mem_we});
               ack_count++;
               cnt = 0;
            end else begin
               bus.mem_ack = 1'b0; cnt++;
            end
         end else begin
            bus.mem_ack = 1'b0; cnt = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_dm(input logic we, input logic [63:0] a, input logic [63:0] wd);
      dm_exp_t e;
      e.rdata = we ? 64'h0 : mem_word(a);
      e.err   = mem_fault(a);
      dm_q.push_back(e);
      bus.dm_we = we; bus.dm_addr = a; bus.dm_wdata = wd; bus.dm_req = 1'b1;
   endtask

   task automatic start_if(input logic [63:0] a);
      if_exp_t e;
      logic [63:0] w0, w1;
      w0 = mem_word(a);
      w1 = mem_word(a + 64'd8);
      if (mem_fault(a)) begin
         e.err = 1'b1; e.chk = 1'b0; e.bytes = '0;
      end else begin
         e.err = mem_fault(a + 64'd8); e.chk = 1'b1; e.bytes = {w1[15:0], w0};
      end
      if_q.push_back(e);
      bus.if_addr = a; bus.if_req = 1'b1;
   endtask

   // Wait for dm_valid, pop the expectation, drop the request, step once more.
   task automatic collect_dm(input int start, output int lat, output dm_exp_t e,
                             output logic [63:0] rd, output logic er, output logic after);
      lat = start;
      while (bus.dm_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
      if (bus.dm_valid !== 1'b1) lat = -1;
      rd = bus.dm_rdata; er = bus.dm_err;
      if (dm_q.size() > 0) e = dm_q.pop_front(); else e = '{64'hx, 1'bx};
      bus.dm_req = 1'b0;
      tick();
      after = bus.dm_valid;
   endtask

   task automatic collect_if(input int start, output int lat, output if_exp_t e,
                             output logic [79:0] by, output logic er, output logic after);
      lat = start;
      while (bus.if_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
      if (bus.if_valid !== 1'b1) lat = -1;
      by = bus.if_bytes; er = bus.if_err;
      if (if_q.size() > 0) e = if_q.pop_front(); else e = '{80'hx, 1'bx, 1'b1};
      bus.if_req = 1'b0;
      tick();
      after = bus.if_valid;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.if_req = 1'b1; bus.dm_req = 1'b1;
      repeat (3) tick();
      vectors++;
      if ({bus.mem_req, bus.if_valid, bus.dm_valid, bus.if_err, bus.dm_err} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctl: {mem_req,if_v,dm_v,if_err,dm_err}=%b want 00000",
                  {bus.mem_req, bus.if_valid, bus.dm_valid, bus.if_err, bus.dm_err});
      end else $display("pass reset_ctl");
      vectors++;
      if (bus.if_bytes !== 80'h0 || bus.dm_rdata !== 64'h0) begin
         miscompares++;
         $display("FAIL reset_data: if_bytes=%h dm_rdata=%h want 0", bus.if_bytes, bus.dm_rdata);
      end else $display("pass reset_data");
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      tick(); reset = 1'b0; tick();
      vectors++;
      if (bus.mem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: mem_req=%b want 0", bus.mem_req);
      end else $display("pass idle_after_reset");
   endtask

   task automatic test_dm_access();
      int lat; dm_exp_t e; logic [63:0] rd; logic er, after;
      ovr[64'h100] = 64'hDEAD_BEEF;
      start_dm(1'b0, 64'h100, 64'h0);
      tick();
      vectors++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 64'h100}) begin
         miscompares++;
         $display("FAIL dm_read_port: req=%b we=%b addr=%h want 1 0 100",
                  bus.mem_req, bus.mem_we, bus.mem_addr);
      end else $display("pass dm_read_port");
      collect_dm(1, lat, e, rd, er, after);
      vectors++;
      if (lat !== 2 || rd !== 64'hDEAD_BEEF || er !== 1'b0 || after !== 1'b0) begin
         miscompares++;
         $display("FAIL dm_read: lat=%0d rdata=%h err=%b after=%b want 2 deadbeef 0 0",
                  lat, rd, er, after);
      end else $display("pass dm_read lat=%0d rdata=%h", lat, rd);
      vectors++;
      if (bus.dm_rdata !== 64'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL dm_hold: rdata=%h want deadbeef", bus.dm_rdata);
      end else $display("pass dm_hold");

      start_dm(1'b1, 64'h200, 64'hCAFE_F00D_1234_5678);
      tick();
      vectors++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
          {1'b1, 1'b1, 64'h200, 64'hCAFE_F00D_1234_5678}) begin
         miscompares++;
         $display("FAIL dm_write_port: req=%b we=%b addr=%h wdata=%h",
                  bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end else $display("pass dm_write_port");
      collect_dm(1, lat, e, rd, er, after);
      vectors++;
      if (lat !== 2 || rd !== e.rdata || er !== e.err) begin
         miscompares++;
         $display("FAIL dm_write: lat=%0d rdata=%h err=%b want 2 %h %b", lat, rd, er, e.rdata, e.err);
      end else $display("pass dm_write rdata=%h", rd);

      err_en = 1'b1; err_addr = 64'h500;
      start_dm(1'b0, 64'h500, 64'h0);
      collect_dm(0, lat, e, rd, er, after);
      vectors++;
      if (lat !== 2 || er !== 1'b1 || rd !== e.rdata) begin
         miscompares++;
         $display("FAIL dm_error: lat=%0d err=%b rdata=%h want 2 1 %h", lat, er, rd, e.rdata);
      end else $display("pass dm_error");
   endtask

   task automatic test_fetch_split();
      int lat; if_exp_t e; logic [79:0] by; logic er, after;
      ovr[64'h3C] = 64'h1122_3344_5566_7788;
      ovr[64'h44] = 64'h9988_7766_5544_AABB;
      grant_q.delete();
      start_if(64'h3C);
      collect_if(0, lat, e, by, er, after);
      vectors++;
      if (lat !== 3 || by !== 80'hAABB_1122_3344_5566_7788 || er !== 1'b0 || after !== 1'b0) begin
         miscompares++;
         $display("FAIL fetch_split: lat=%0d bytes=%h err=%b after=%b want 3 aabb1122334455667788 0 0",
                  lat, by, er, after);
      end else $display("pass fetch_split bytes=%h", by);
      vectors++;
      if (grant_q.size() != 2 || grant_q[0].addr !== 64'h3C || grant_q[1].addr !== 64'h44) begin
         miscompares++;
         $display("FAIL fetch_addrs: count=%0d first=%h second=%h want 2 3c 44", grant_q.size(),
                  grant_q.size() > 0 ? grant_q[0].addr : 64'hx,
                  grant_q.size() > 1 ? grant_q[1].addr : 64'hx);
      end else $display("pass fetch_addrs");
   endtask

   task automatic test_fetch_error_wrap();
      int lat; if_exp_t e; logic [79:0] by; logic er, after;
      grant_q.delete();
      start_if(64'h500);
      collect_if(0, lat, e, by, er, after);
      vectors++;
      if (lat !== 2 || er !== 1'b1 || grant_q.size() != 1) begin
         miscompares++;
         $display("FAIL fetch_error: lat=%0d err=%b accesses=%0d want 2 1 1", lat, er, grant_q.size());
      end else $display("pass fetch_error");
      err_en = 1'b0;
      grant_q.delete();
      start_if(64'hFFFF_FFFF_FFFF_FFFC);
      collect_if(0, lat, e, by, er, after);
      vectors++;
      if (lat !== 3 || by !== e.bytes || er !== 1'b0 || grant_q.size() != 2 ||
          grant_q[1].addr !== 64'h4) begin
         miscompares++;
         $display("FAIL fetch_wrap: lat=%0d bytes=%h want %h accesses=%0d second=%h want 4",
                  lat, by, e.bytes, grant_q.size(), grant_q.size() > 1 ? grant_q[1].addr : 64'hx);
      end else $display("pass fetch_wrap bytes=%h", by);
   endtask

   task automatic test_wait_states();
      int lat; dm_exp_t de; if_exp_t ie; logic [63:0] rd; logic [79:0] by; logic er, after;
      mem_wait = 3; addr_moved = 1'b0;
      start_dm(1'b0, 64'h300, 64'h0);
      collect_dm(0, lat, de, rd, er, after);
      vectors++;
      if (lat !== 5 || rd !== de.rdata || er !== de.err || addr_moved !== 1'b0) begin
         miscompares++;
         $display("FAIL dm_wait: lat=%0d rdata=%h moved=%b want 5 %h 0", lat, rd, addr_moved, de.rdata);
      end else $display("pass dm_wait lat=%0d", lat);
      start_if(64'h340);
      collect_if(0, lat, ie, by, er, after);
      vectors++;
      if (lat !== 9 || by !== ie.bytes || er !== ie.err || addr_moved !== 1'b0) begin
         miscompares++;
         $display("FAIL if_wait: lat=%0d bytes=%h moved=%b want 9 %h 0", lat, by, addr_moved, ie.bytes);
      end else $display("pass if_wait lat=%0d", lat);
   endtask

   task automatic test_reset_mid_fetch();
      int a0, n; if_exp_t dummy; logic bad;
      mem_wait = 3;
      a0 = ack_count;
      start_if(64'h600);
      dummy = if_q.pop_back();   // this fetch is abandoned
      n = 0;
      while (ack_count == a0 && n < 20) begin tick(); n++; end
      vectors++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h608) begin
         miscompares++;
         $display("FAIL if1_entry: mem_req=%b addr=%h want 1 608", bus.mem_req, bus.mem_addr);
      end else $display("pass if1_entry");
      tick();
      reset = 1'b1; bus.if_req = 1'b0;
      tick();
      vectors++;
      if (bus.mem_req !== 1'b0 || bus.if_valid !== 1'b0 || bus.if_bytes !== 80'h0) begin
         miscompares++;
         $display("FAIL reset_abort: mem_req=%b if_valid=%b bytes=%h want 0 0 0",
                  bus.mem_req, bus.if_valid, bus.if_bytes);
      end else $display("pass reset_abort");
      reset = 1'b0; stray_ack = 2;
      bad = 1'b0;
      repeat (6) begin
         tick();
         bad = bad | bus.mem_req | bus.if_valid | bus.dm_valid;
      end
      vectors++;
      if (bad !== 1'b0 || bus.dm_rdata !== 64'h0 || bus.dm_err !== 1'b0 || bus.if_err !== 1'b0) begin
         miscompares++;
         $display("FAIL stray_ack: activity=%b dm_rdata=%h dm_err=%b if_err=%b want 0 0 0 0",
                  bad, bus.dm_rdata, bus.dm_err, bus.if_err);
      end else $display("pass stray_ack");
      mem_wait = 0;
   endtask

   task automatic test_contention();
      string order; logic data_bad, resp_grant; int nv, n;
      dm_exp_t de; if_exp_t ie;
      reset = 1'b1;
      tick();
      start_dm(1'b0, 64'h700, 64'h0);
      start_if(64'h800);
      start_dm(1'b0, 64'h700, 64'h0);
      tick(); reset = 1'b0;
      order = ""; data_bad = 1'b0; resp_grant = 1'b0; nv = 0; n = 0;
      while (nv < 3 && n < 60) begin
         tick(); n++;
         if ((bus.if_valid === 1'b1 || bus.dm_valid === 1'b1) && bus.mem_req !== 1'b0) resp_grant = 1'b1;
         if (bus.dm_valid === 1'b1) begin
            order = {order, "D"}; nv++;
            if (dm_q.size() > 0) begin
               de = dm_q.pop_front();
               if (bus.dm_rdata !== de.rdata || bus.dm_err !== de.err) data_bad = 1'b1;
            end else data_bad = 1'b1;
         end
         if (bus.if_valid === 1'b1) begin
            order = {order, "I"}; nv++;
            if (if_q.size() > 0) begin
               ie = if_q.pop_front();
               if (bus.if_bytes !== ie.bytes || bus.if_err !== ie.err) data_bad = 1'b1;
            end else data_bad = 1'b1;
         end
         if (nv >= 3) begin bus.dm_req = 1'b0; bus.if_req = 1'b0; end
      end
      bus.dm_req = 1'b0; bus.if_req = 1'b0;
      tick();
      vectors++;
      if (order != "DID" || data_bad !== 1'b0 || resp_grant !== 1'b0) begin
         miscompares++;
         $display("FAIL contention: order=%s data_bad=%b resp_grant=%b want DID 0 0",
                  order, data_bad, resp_grant);
      end else $display("pass contention order=%s", order);
   endtask

   task automatic test_back_to_back();
      int lat, w, want; dm_exp_t de; if_exp_t ie;
      logic [63:0] rd, a; logic [79:0] by; logic er, after, we;
      for (int i = 0; i < 8; i++) begin
         w = $urandom_range(0, 2);
         mem_wait = w;
         a = {$urandom, $urandom};
         if (((i % 2) == 0) ^ ($urandom_range(0, 3) == 0)) begin
            we = 1'($urandom_range(0, 1));
            want = 2 + w;
            start_dm(we, a, {$urandom, $urandom});
            collect_dm(0, lat, de, rd, er, after);
            vectors++;
            if (lat !== want || rd !== de.rdata || er !== de.err || after !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_dm[%0d]: lat=%0d rdata=%h err=%b want %0d %h %b",
                        i, lat, rd, er, want, de.rdata, de.err);
            end else $display("pass b2b_dm[%0d] we=%b addr=%h lat=%0d", i, we, a, lat);
         end else begin
            want = 3 + 2 * w;
            start_if(a);
            collect_if(0, lat, ie, by, er, after);
            vectors++;
            if (lat !== want || by !== ie.bytes || er !== ie.err || after !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_if[%0d]: lat=%0d bytes=%h err=%b want %0d %h %b",
                        i, lat, by, er, want, ie.bytes, ie.err);
            end else $display("pass b2b_if[%0d] addr=%h lat=%0d", i, a, lat);
         end
      end
      mem_wait = 0;
   endtask

   initial begin
      reset = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      test_reset();
      test_dm_access();
      test_fetch_split();
      test_fetch_error_wrap();
      test_wait_states();
      test_reset_mid_fetch();
      test_contention();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
  clk  in  1  single clock; all state on rising edge.
  reset  in  1  synchronous, active-high reset.
  if_req  in  1  fetch-stage read request; held until if_valid.
  if_addr  in  64  fetch byte address (f_pc); held with if_req.
  if_valid  out  1  one-cycle pulse; if_bytes/if_err valid.
  if_bytes  out  80  instruction bytes addr..addr+9, byte 0 in [7:0].
  if_err  out  1  imem_error for this fetch.
  dm_req  in  1  memory-stage request; held until dm_valid.
  dm_we  in  1  1 = write, 0 = read; held with dm_req.
  dm_addr  in  64  data byte address; held.
  dm_wdata  in  64  write data; held.
  dm_valid  out  1  one-cycle pulse; dm_rdata/dm_err valid.
  dm_rdata  out  64  read data (0 for writes).
  dm_err  out  1  dmem_error for this access.
  mem_req  out  1  shared unified-memory port request.
  mem_we  out  1  port write enable.
  mem_addr  out  64  port byte address; returns 8 bytes from addr.
  mem_wdata  out  64  port write data.
  mem_ack  in  1  access complete this cycle; latency >= 0 cycles after mem_req.
  mem_rdata  in  64  read data, valid with mem_ack.
  mem_err  in  1  address error, valid with mem_ack.

Function
REQ-002 SHALL share one memory port between fetch and data requesters via FSM states IDLE, DM, IF0, IF1, RESP.
REQ-003 IDLE: only dm_req -> DM; only if_req -> IF0; both -> grant requester not served last (last_dm flag), DM when flag clear; none -> IDLE.
REQ-004 mem_req SHALL be 1 exactly in DM, IF0, IF1; mem_addr/mem_we/mem_wdata stable until mem_ack.
REQ-005 DM: mem_addr=dm_addr, mem_we=dm_we, mem_wdata=dm_wdata; on mem_ack register rdata (0 if write) and err, set last_dm=1, -> RESP.
REQ-006 IF0: mem_addr=if_addr, mem_we=0; on mem_ack store mem_rdata as bytes 0-7; mem_err=1 -> RESP with if_err=1, else -> IF1.
REQ-007 IF1: mem_addr=if_addr+8 (mod 2^64, wraps), mem_we=0; on mem_ack store mem_rdata[15:0] as bytes 8-9, if_err=mem_err, last_dm=0, -> RESP.
REQ-008 RESP: assert exactly one of if_valid/dm_valid for one cycle; no new grant; -> IDLE unconditionally.
REQ-009 Minimum latency with zero-wait memory: dm_req at IDLE cycle t -> dm_valid at t+2; if_req at t -> if_valid at t+3.
REQ-010 if_bytes/dm_rdata/err outputs SHALL hold their last value outside valid pulses.
REQ-011 mem_ack in IDLE or RESP SHALL be ignored.
REQ-012 Requests SHALL be sampled only in IDLE; req changes during an access do not affect it.
REQ-013 Neither requester SHALL wait more than one other access when both are held (alternation).

Reset
REQ-014 reset=1 at a rising edge SHALL force state IDLE, last_dm=0, if_bytes=0, dm_rdata=0, if_err=0, dm_err=0; valid outputs and mem_req 0 in the next cycle.
REQ-015 Reset mid-access SHALL abandon it: no valid pulse, partial fetch bytes discarded, pending mem_ack ignored.

Structure
REQ-016 FSM state encoding, 64-bit word/address widths, 80-bit instruction width SHALL live in shared package y86_pkg with existing icode/stat constants.
REQ-017 Single module; no sub-module. Pipeline stall logic stays outside and derives stalls from req & ~valid.

Verification
REQ-018 Zero-wait read: dm_req=1, dm_we=0, dm_addr=0x100, mem returns 0xDEADBEEF -> mem_req 1 cycle later, dm_valid at t+2, dm_rdata=0xDEADBEEF, dm_err=0.
REQ-019 Fetch split: if_addr=0x3C, mem returns 0x1122334455667788 then 0x..AABB -> mem_addr 0x3C then 0x44, if_bytes=0xAABB1122334455667788, if_valid at t+3.
REQ-020 Contention: if_req and dm_req held from reset -> DM served first, then IF, then DM; no grant during any RESP.
REQ-021 Fetch error: mem_err=1 on IF0 ack -> no IF1 access, if_valid with if_err=1; wrap: if_addr=0xFFFFFFFFFFFFFFFC -> second mem_addr=0x4.
REQ-022 Wait states + reset: mem_ack delayed 3 cycles keeps mem_addr stable; reset asserted in IF1 -> next cycle mem_req=0, no if_valid, late mem_ack ignored.
